traffic_light_sequencer: RTL and testbench

//  Timed phase sequencer for one signalised approach. Drives the 2-bit state

---
 rtl/traffic_light_sequencer.sv | 79 +++++++
 tb/tb_traffic_light_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: timed RED->GREEN->YELLOW phase sequencer with ped shortening and fault override
// Ports: i_clk/i_rst (async, active-high), i_en tick enable, i_ped_req pedestrian request,
//        i_fault fault level; o_state 00 RED/01 GREEN/10 YELLOW/11 FAULT, o_remaining
//        enabled cycles left minus 1, o_phase_done new-phase pulse, o_ped_ack service pulse.
module traffic_light_sequencer #(
  parameter int CNT_W     = 8,
  parameter int RED_T     = 8,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int MIN_GREEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ped_req,
  input  logic             i_fault,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_phase_done,
  output logic             o_ped_ack
);
  localparam logic [1:0] S_RED    = 2'b00;
  localparam logic [1:0] S_GREEN  = 2'b01;
  localparam logic [1:0] S_YELLOW = 2'b10;
  localparam logic [1:0] S_FAULT  = 2'b11;
  localparam logic [CNT_W-1:0] L_RED = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] L_GREEN = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_CUT = CNT_W'(GREEN_T - MIN_GREEN);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_rem;
  logic             r_done;
  logic             r_ack;
  logic             r_pend;
  logic             w_pend;
  logic             w_adv;
  logic [1:0]       w_nxt;
  logic [CNT_W-1:0] w_load;
  // A request arriving this cycle counts as pending for both the GREEN cut and the YELLOW->RED ack.
  always_comb begin
    w_pend = r_pend | i_ped_req;
    w_adv  = i_en && (r_rem == '0 || (r_state == S_GREEN && w_pend && r_rem <= L_CUT));
    w_nxt  = r_state == S_RED ? S_GREEN : r_state == S_GREEN ? S_YELLOW : S_RED;
    w_load = r_state == S_RED ? L_GREEN : r_state == S_GREEN ? L_YELLOW : L_RED;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RED;
      r_rem   <= L_RED;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ack  <= 1'b0;
      r_pend <= w_pend;
      if (i_fault) begin
        r_state <= S_FAULT;
      end else if (r_state == S_FAULT) begin
        r_state <= S_RED;
        r_rem   <= L_RED;
      end else if (w_adv) begin
        r_state <= w_nxt;
        r_rem   <= w_load;
        r_done  <= 1'b1;
        if (r_state == S_YELLOW) begin
          r_ack  <= w_pend;
          r_pend <= 1'b0;
        end
      end else if (i_en) begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end
  assign o_state      = r_state;
  assign o_remaining  = r_rem;
  assign o_phase_done = r_done;
  assign o_ped_ack    = r_ack;
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: directed self-checking bench for traffic_light_sequencer
module tb_traffic_light_sequencer;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0;
  logic       i_ped_req = 1'b0;
  logic       i_fault = 1'b0;
  logic [1:0] o_state;
  logic [7:0] o_remaining;
  logic       o_phase_done;
  logic       o_ped_ack;
  int total = 0;
  int bad = 0;
  traffic_light_sequencer dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(i_en),
    .i_ped_req(i_ped_req),
    .i_fault(i_fault),
    .o_state(o_state),
    .o_remaining(o_remaining),
    .o_phase_done(o_phase_done),
    .o_ped_ack(o_ped_ack)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int st, input int rem, input int done, input int ack);
    chk({tag, ".state"}, {30'd0, o_state}, st);
    chk({tag, ".rem"}, {24'd0, o_remaining}, rem);
    chk({tag, ".done"}, {31'd0, o_phase_done}, done);
    chk({tag, ".ack"}, {31'd0, o_ped_ack}, ack);
  endtask
  initial begin
    tick(2);
    chk_all("reset", 0, 7, 0, 0);
    i_rst = 1'b0;
    i_en = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick(1);
      chk("t1.state", {30'd0, o_state}, k < 8 ? 0 : k < 18 ? 1 : k < 21 ? 2 : 0);
      chk("t1.rem", {24'd0, o_remaining}, k < 8 ? 7 - k : k < 18 ? 17 - k : k < 21 ? 20 - k : 7);
      chk("t1.done", {31'd0, o_phase_done}, (k == 8 || k == 18 || k == 21) ? 1 : 0);
    end
    chk("t1.ack", {31'd0, o_ped_ack}, 0);
    tick(8);
    chk_all("t2.green0", 1, 9, 1, 0);
    tick(1);
    i_ped_req = 1'b1;
    tick(1);
    i_ped_req = 1'b0;
    chk_all("t2.green2", 1, 7, 0, 0);
    tick(1);
    chk_all("t2.green3", 1, 6, 0, 0);
    tick(1);
    chk_all("t2.yellow", 2, 2, 1, 0);
    tick(3);
    chk_all("t2.red_ack", 0, 7, 1, 1);
    tick(1);
    chk_all("t2.ack_off", 0, 6, 0, 0);
    tick(7);
    chk_all("t2b.green0", 1, 9, 1, 0);
    tick(7);
    chk_all("t2b.green7", 1, 2, 0, 0);
    i_ped_req = 1'b1;
    tick(1);
    i_ped_req = 1'b0;
    chk_all("t2b.yellow", 2, 2, 1, 0);
    tick(3);
    chk_all("t2b.red_ack", 0, 7, 1, 1);
    for (int i = 0; i <= 14; i++) begin
      i_en = (i % 2 == 1);
      tick(1);
      chk("t3.rem", {24'd0, o_remaining}, 7 - (i + 1) / 2);
      chk("t3.state", {30'd0, o_state}, 0);
    end
    i_en = 1'b1;
    tick(1);
    chk_all("t3.green", 1, 9, 1, 0);
    i_en = 1'b0;
    tick(1);
    chk_all("t3.frozen", 1, 9, 0, 0);
    i_en = 1'b1;
    tick(3);
    chk_all("t4.pre", 1, 6, 0, 0);
    i_fault = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("t4.fault", 3, 6, 0, 0);
    end
    i_fault = 1'b0;
    tick(1);
    chk_all("t4.recover", 0, 7, 0, 0);
    tick(8);
    chk_all("t5.green0", 1, 9, 1, 0);
    i_ped_req = 1'b1;
    tick(1);
    i_ped_req = 1'b0;
    tick(3);
    chk_all("t5.yellow", 2, 2, 1, 0);
    #2 i_rst = 1'b1;
    #1 chk_all("t5.async", 0, 7, 0, 0);
    tick(1);
    i_rst = 1'b0;
    tick(12);
    chk_all("t5.full_green", 1, 5, 0, 0);
    tick(6);
    chk_all("t5.yellow2", 2, 2, 1, 0);
    tick(3);
    chk_all("t5.no_ack", 0, 7, 1, 0);
    i_ped_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick(8);
      chk_all("t6.green0", 1, 9, 1, 0);
      tick(3);
      chk_all("t6.green3", 1, 6, 0, 0);
      tick(1);
      chk_all("t6.yellow", 2, 2, 1, 0);
      tick(3);
      chk_all("t6.red_ack", 0, 7, 1, 1);
    end
    tick(1);
    chk_all("t6.ack_once", 0, 6, 0, 0);
    i_ped_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
